legv8_flag_branch_unit: RTL and testbench
=========================================

Name: legv8_flag_branch_unit

Overview:
Consumer end of the ALU flag interface. Holds the architectural NZCV condition register, updated from ALU flag outputs on flag-setting instructions (ADDS/SUBS/ANDS). Resolves B.cond/CBZ/CBNZ/B requests over a valid/ready handshake and returns a registered taken decision to the PC-select logic. Sits between the ALU and next-PC mux; keeps taken/resolved statistics counters.

Parameters:
CNT_W, 32, width of the resolved-branch and taken-branch counters (saturating).

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  reset, asynchronous, active-high
iSetFlags  in  1  latch iFlagN/Z/C/V into NZCV this edge
iFlagN  in  1  ALU negative flag
iFlagZ  in  1  ALU zero flag
iFlagC  in  1  ALU carry flag
iFlagV  in  1  ALU overflow flag
iZero  in  1  ALU oZero (register-compare result for CBZ/CBNZ)
iReqValid  in  1  branch request valid
oReqReady  out  1  unit can accept a request
iBrType  in  2  0=B (always), 1=B.cond, 2=CBZ, 3=CBNZ
iCond  in  4  ARM condition code, used only when iBrType=1
oResValid  out  1  decision valid
iResReady  in  1  consumer accepts decision
oTaken  out  1  branch taken; meaningful only while oResValid=1
oNZCV  out  4  current flag register {N,Z,C,V}
oResolvedCnt  out  CNT_W  number of accepted requests
oTakenCnt  out  CNT_W  number of accepted requests resolved taken

Behaviour:
- Reset (async, immediate): NZCV=4'b0000, FSM=IDLE, oReqReady=1, oResValid=0, oTaken=0, both counters=0.
- Flag register: on each edge with iSetFlags=1, NZCV <= {iFlagN,iFlagZ,iFlagC,iFlagV}; otherwise it holds. Independent of FSM state.
- FSM IDLE: oReqReady=1, oResValid=0. When iReqValid=1, the request is accepted at the edge. At that edge oTaken is registered from the evaluated condition, state goes to RESP, oResolvedCnt increments, and oTakenCnt increments if taken.
- FSM RESP: oReqReady=0, oResValid=1, oTaken held stable. When iResReady=1, the state returns to IDLE at the edge. Back-to-back throughput is therefore 1 request per 2 cycles. iReqValid is ignored while in RESP.
- Latency: decision is visible 1 cycle after acceptance.
- Evaluation:
  - iBrType=0: taken=1.
  - iBrType=2: taken=iZero.
  - iBrType=3: taken=~iZero.
  - iBrType=1, evaluated on flags F:
    - 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C
    - 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
    - 8 HI C&~Z; 9 LS ~(C&~Z)
    - A GE N==V; B LT N!=V
    - C GT ~Z&(N==V); D LE ~(~Z&(N==V))
    - E AL 1; F NV 1
- Simultaneous iSetFlags and acceptance: F is the old register value (without the optional feature). NZCV still updates.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-RESP: the pending decision is discarded and oResValid drops immediately.
- X on iCond/iBrType when iReqValid=0 must not affect state.

Optional Feature:
FLAG_FWD_EN. When defined, if iSetFlags=1 in the accept cycle, B.cond evaluates on the incoming {iFlagN,iFlagZ,iFlagC,iFlagV} (bypass). When undefined, it always evaluates on the registered NZCV. The register update is identical in both builds.

Decomposition:
- Shared package (alongside existing Parametros): brtype enum (BR_B, BR_COND, BR_CBZ, BR_CBNZ), condition-code constants COND_EQ..COND_NV, and the FSM state typedef {ST_IDLE, ST_RESP}.
- One natural sub-module: legv8_cond_eval. It is purely combinational, taking a 4-bit cond and NZCV and producing a 1-bit pass. It is reused by a future conditional-select (CSEL) datapath.

Test Plan:
- Reset mid-RESP: reset asserted while oResValid=1 -> oResValid=0, oReqReady=1, oNZCV=0000, counters 0, all without a clock edge.
- Flags then cond: iSetFlags with N=1,Z=0,C=0,V=0. Next cycle, request B.cond with cond=B (LT) -> oTaken=1 one cycle later; cond=A (GE) -> oTaken=0; cond=C (GT) -> 0.
- Unsigned compares: NZCV=0010 (C=1,Z=0) gives HI=1, LS=0. NZCV=0110 (Z=1,C=1) gives HI=0, LS=1. CBZ with iZero=1 gives taken=1; CBNZ with iZero=1 gives taken=0.
- Handshake stall: oResValid=1 with iResReady held 0 for 5 cycles. oTaken stays stable and oReqReady stays 0; a new iReqValid in that window is not counted (oResolvedCnt unchanged).
- Same-cycle set+accept: NZCV=0000, iSetFlags with Z=1 and B.cond EQ in the same cycle. Without FLAG_FWD_EN -> oTaken=0; with it -> oTaken=1. oNZCV=0100 afterwards in both builds.
- Counter saturation (CNT_W=4): 20 accepted B requests -> oResolvedCnt=oTakenCnt=15, no wrap.

Source files
------------

// File: rtl/legv8_flag_branch_unit_pkg.sv
// ============================================================================
//  Module      : legv8_flag_branch_unit_pkg
//  Description : Shared types and constants for the LEGv8 flag/branch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package legv8_flag_branch_unit_pkg;

   typedef enum logic [1:0] {
      BR_B    = 2'd0,
      BR_COND = 2'd1,
      BR_CBZ  = 2'd2,
      BR_CBNZ = 2'd3
   } brtype_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_HS = 4'h2;
   localparam logic [3:0] COND_LO = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef logic [0:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE = 1'b0;
   localparam fsm_state_t ST_RESP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/legv8_cond_eval.sv
// ============================================================================
//  Module      : legv8_cond_eval
//  Description : Combinational ARM condition-code evaluator on {N,Z,C,V}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module legv8_cond_eval
   import legv8_flag_branch_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_HS: pass = c;
         COND_LO: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~(c & ~z);
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = ~(~z & (n == v));
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/legv8_flag_branch_unit.sv
// ============================================================================
//  Module      : legv8_flag_branch_unit
//  Description : NZCV register plus branch resolver with valid/ready handshake
//                and saturating statistics. Optional macro FLAG_FWD_EN lets
//                B.cond see flags being written in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module legv8_flag_branch_unit
   import legv8_flag_branch_unit_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSetFlags,
   input  logic             iFlagN,
   input  logic             iFlagZ,
   input  logic             iFlagC,
   input  logic             iFlagV,
   input  logic             iZero,
   input  logic             iReqValid,
   output logic             oReqReady,
   input  logic [1:0]       iBrType,
   input  logic [3:0]       iCond,
   output logic             oResValid,
   input  logic             iResReady,
   output logic             oTaken,
   output logic [3:0]       oNZCV,
   output logic [CNT_W-1:0] oResolvedCnt,
   output logic [CNT_W-1:0] oTakenCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   fsm_state_t       state;
   logic [3:0]       nzcv;
   logic             taken;
   logic [CNT_W-1:0] resolved_cnt;
   logic [CNT_W-1:0] taken_cnt;

   logic [3:0] flags_in;
   logic [3:0] eval_flags;
   logic       cond_pass;
   logic       taken_eval;
   logic       accept;

   assign flags_in = {iFlagN, iFlagZ, iFlagC, iFlagV};
   assign accept   = (state == ST_IDLE) && iReqValid;

`ifdef FLAG_FWD_EN
   assign eval_flags = iSetFlags ? flags_in : nzcv;
`else
   assign eval_flags = nzcv;
`endif

   legv8_cond_eval u_cond_eval (
      .cond (iCond),
      .nzcv (eval_flags),
      .pass (cond_pass)
   );

   always_comb begin
      taken_eval = 1'b0;
      case (brtype_t'(iBrType))
         BR_B:    taken_eval = 1'b1;
         BR_COND: taken_eval = cond_pass;
         BR_CBZ:  taken_eval = iZero;
         BR_CBNZ: taken_eval = ~iZero;
         default: taken_eval = 1'b0;
      endcase
   end

   // Flag register runs independently of the handshake FSM.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         nzcv <= 4'b0000;
      end else if (iSetFlags) begin
         nzcv <= flags_in;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state        <= ST_IDLE;
         taken        <= 1'b0;
         resolved_cnt <= '0;
         taken_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_RESP;
                  taken <= taken_eval;
                  if (resolved_cnt != CNT_MAX) begin
                     resolved_cnt <= resolved_cnt + CNT_ONE;
                  end
                  if (taken_eval && (taken_cnt != CNT_MAX)) begin
                     taken_cnt <= taken_cnt + CNT_ONE;
                  end
               end
            end
            ST_RESP: begin
               if (iResReady) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign oReqReady    = (state == ST_IDLE);
   assign oResValid    = (state == ST_RESP);
   assign oTaken       = taken;
   assign oNZCV        = nzcv;
   assign oResolvedCnt = resolved_cnt;
   assign oTakenCnt    = taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_legv8_flag_branch_unit.sv
// ============================================================================
//  Module      : tb_legv8_flag_branch_unit
//  Description : Self-checking bench for legv8_flag_branch_unit (CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_legv8_flag_branch_unit;

   localparam int CNT_W   = 4;
   localparam int CNT_TOP = (1 << CNT_W) - 1;

   logic             iCLK = 1'b0;
   logic             iRST;
   logic             iSetFlags, iFlagN, iFlagZ, iFlagC, iFlagV, iZero;
   logic             iReqValid, iResReady;
   logic [1:0]       iBrType;
   logic [3:0]       iCond;
   logic             oReqReady, oResValid, oTaken;
   logic [3:0]       oNZCV;
   logic [CNT_W-1:0] oResolvedCnt, oTakenCnt;

   legv8_flag_branch_unit #(.CNT_W(CNT_W)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSetFlags(iSetFlags),
      .iFlagN(iFlagN), .iFlagZ(iFlagZ), .iFlagC(iFlagC), .iFlagV(iFlagV),
      .iZero(iZero), .iReqValid(iReqValid), .oReqReady(oReqReady),
      .iBrType(iBrType), .iCond(iCond), .oResValid(oResValid),
      .iResReady(iResReady), .oTaken(oTaken), .oNZCV(oNZCV),
      .oResolvedCnt(oResolvedCnt), .oTakenCnt(oTakenCnt)
   );

   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_pass   = 0;

   bit [3:0] m_nzcv;
   bit       m_resp;
   bit       m_taken;
   int       m_res;
   int       m_tak;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Conditions come in pairs: even codes test a base predicate, odd codes negate it.
   function automatic bit m_eval(input int br, input int cond, input bit [3:0] f, input bit z);
      bit n, zf, c, v, base;
      n = f[3]; zf = f[2]; c = f[1]; v = f[0];
      if (br == 0) return 1'b1;
      if (br == 2) return z;
      if (br == 3) return !z;
      if (cond >= 14) return 1'b1;
      case (cond / 2)
         0: base = zf;
         1: base = c;
         2: base = n;
         3: base = v;
         4: base = c && !zf;
         5: base = (n == v);
         default: base = !zf && (n == v);
      endcase
      return (cond % 2 == 1) ? !base : base;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".ready"}, 32'(oReqReady), 32'(!m_resp));
      check({tag, ".valid"}, 32'(oResValid), 32'(m_resp));
      check({tag, ".nzcv"}, 32'(oNZCV), 32'(m_nzcv));
      check({tag, ".rescnt"}, 32'(oResolvedCnt), 32'(m_res));
      check({tag, ".takcnt"}, 32'(oTakenCnt), 32'(m_tak));
      if (m_resp) check({tag, ".taken"}, 32'(oTaken), 32'(m_taken));
   endtask

   task automatic tick(input string tag);
      bit [3:0] f_in;
      bit [3:0] f_eval;
      bit       t;
      f_in = {iFlagN, iFlagZ, iFlagC, iFlagV};
      if (!m_resp && iReqValid) begin
         f_eval = m_nzcv;
`ifdef FLAG_FWD_EN
         if (iSetFlags) f_eval = f_in;
`endif
         t       = m_eval(int'(iBrType), int'(iCond), f_eval, iZero);
         m_taken = t;
         m_resp  = 1'b1;
         if (m_res < CNT_TOP) m_res++;
         if (t && m_tak < CNT_TOP) m_tak++;
      end else if (m_resp && iResReady) begin
         m_resp = 1'b0;
      end
      if (iSetFlags) m_nzcv = f_in;
      @(posedge iCLK);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle_inputs();
      iSetFlags = 0; iFlagN = 0; iFlagZ = 0; iFlagC = 0; iFlagV = 0;
      iZero = 0; iReqValid = 0; iResReady = 0; iBrType = 2'd0; iCond = 4'h0;
   endtask

   task automatic set_flags(input bit [3:0] f);
      iSetFlags = 1; {iFlagN, iFlagZ, iFlagC, iFlagV} = f;
      tick("setf");
      iSetFlags = 0;
   endtask

   task automatic req(input string tag, input bit [1:0] br, input bit [3:0] cond,
                      input bit z, input bit exp);
      iReqValid = 1; iBrType = br; iCond = cond; iZero = z;
      tick(tag);
      check({tag, ".const"}, 32'(oTaken), 32'(exp));
      iReqValid = 0; iResReady = 1;
      tick({tag, ".rel"});
      iResReady = 0;
   endtask

   task automatic hard_reset_clear_model();
      m_nzcv = 0; m_resp = 0; m_taken = 0; m_res = 0; m_tak = 0;
   endtask

   initial begin
      bit       t0;
      bit       exp_same;
      logic [CNT_W-1:0] cnt0;

      idle_inputs();
      iRST = 1;
      hard_reset_clear_model();
      #2;
      check_outputs("reset");
      @(negedge iCLK);
      iRST = 0;

      // Signed compare after N=1
      set_flags(4'b1000);
      req("lt", 2'd1, 4'hB, 0, 1'b1);
      req("ge", 2'd1, 4'hA, 0, 1'b0);
      req("gt", 2'd1, 4'hC, 0, 1'b0);

      // Unsigned compares and compare-and-branch
      set_flags(4'b0010);
      req("hi1", 2'd1, 4'h8, 0, 1'b1);
      req("ls1", 2'd1, 4'h9, 0, 1'b0);
      set_flags(4'b0110);
      req("hi2", 2'd1, 4'h8, 0, 1'b0);
      req("ls2", 2'd1, 4'h9, 0, 1'b1);
      req("cbz", 2'd2, 4'h0, 1, 1'b1);
      req("cbnz", 2'd3, 4'h0, 1, 1'b0);
      req("nv", 2'd1, 4'hF, 0, 1'b1);

      // Stall with a competing request held high
      iReqValid = 1; iBrType = 2'd3; iZero = 0;
      tick("stall.acc");
      t0 = oTaken;
      cnt0 = oResolvedCnt;
      iResReady = 0;
      for (int i = 0; i < 5; i++) begin
         tick("stall");
         check("stall.hold", 32'(oTaken), 32'(t0));
         check("stall.cnt", 32'(oResolvedCnt), 32'(cnt0));
      end
      iReqValid = 0; iResReady = 1;
      tick("stall.rel");
      iResReady = 0;

      // Flag write and EQ request in the same cycle
      set_flags(4'b0000);
`ifdef FLAG_FWD_EN
      exp_same = 1'b1;
`else
      exp_same = 1'b0;
`endif
      iSetFlags = 1; {iFlagN, iFlagZ, iFlagC, iFlagV} = 4'b0100;
      req("same", 2'd1, 4'h0, 0, exp_same);
      iSetFlags = 0;
      check("same.nzcv", 32'(oNZCV), 32'h4);

      // Asynchronous reset while a decision is pending
      iReqValid = 1; iBrType = 2'd0;
      tick("mid.acc");
      iReqValid = 0;
      #2;
      iRST = 1;
      hard_reset_clear_model();
      #1;
      check_outputs("midrst");
      idle_inputs();
      @(negedge iCLK);
      iRST = 0;

      for (int i = 0; i < 300; i++) begin
         iSetFlags = ($urandom % 3) == 0;
         {iFlagN, iFlagZ, iFlagC, iFlagV} = 4'($urandom);
         iZero     = 1'($urandom);
         iReqValid = 1'($urandom);
         iBrType   = 2'($urandom);
         iCond     = 4'($urandom);
         iResReady = 1'($urandom);
         tick("rand");
      end
      idle_inputs();
      iResReady = 1;
      tick("drain");
      iResReady = 0;

      // Saturation from a clean start
      iRST = 1;
      hard_reset_clear_model();
      #1;
      idle_inputs();
      @(negedge iCLK);
      iRST = 0;
      for (int i = 0; i < 20; i++) req("sat", 2'd0, 4'h0, 0, 1'b1);
      check("sat.res", 32'(oResolvedCnt), 32'd15);
      check("sat.tak", 32'(oTakenCnt), 32'd15);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
